rotary_encoder_v3: RTL and testbench



---
 rtl/rotary_pkg.sv | 28 ++
 rtl/rotary_quad_decoder.sv | 52 +++++
 rtl/rotary_encoder_v3.sv | 124 ++++++++++++
 tb/tb_rotary_encoder_v3.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared constants and helpers for front-panel rotary encoder knobs.
package rotary_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Default range for tune-style knobs (14-bit, centred)
  localparam int unsigned TUNE_MIN    = 0;
  localparam int unsigned TUNE_MAX    = 16383;
  localparam int unsigned TUNE_CENTER = 8192;

  function automatic int unsigned step_shift(input logic        coarse,
                                             input int unsigned fine_shift,
                                             input int unsigned coarse_shift);
    return coarse ? coarse_shift : fine_shift;
  endfunction

  function automatic logic [31:0] clamp_u32(input logic [31:0] x,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    logic [31:0] r;
    r = x;
    if (x < lo) r = lo;
    if (x > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/rotary_quad_decoder.sv
// Quadrature front end: 2-flop sync, q1/q2 detent filter and q1 rising-edge event.
module rotary_quad_decoder
  import rotary_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  output logic event_o,
  output logic dir_o
);

  logic [1:0] s1_q, s2_q;
  logic       q1_q, q1_d, q2_q, q2_d, q1_dly_q;
  logic       event_q, dir_q;

  // q1 marks a completed detent, q2 remembers which contact led
  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    unique case (s2_q)
      2'b00:   q1_d = 1'b0;
      2'b01:   q2_d = DIR_UP;
      2'b10:   q2_d = DIR_DOWN;
      default: q1_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 2'b00;
      s2_q     <= 2'b00;
      q1_q     <= 1'b0;
      q2_q     <= 1'b0;
      q1_dly_q <= 1'b0;
      event_q  <= 1'b0;
      dir_q    <= DIR_UP;
    end else begin
      s1_q     <= {b_i, a_i};
      s2_q     <= s1_q;
      q1_q     <= q1_d;
      q2_q     <= q2_d;
      q1_dly_q <= q1_q;
      event_q  <= q1_q & ~q1_dly_q;
      dir_q    <= q2_q;
    end
  end

  assign event_o = event_q;
  assign dir_o   = dir_q;

endmodule

// File: rtl/rotary_encoder_v3.sv
// Rotary encoder input to bounded parameter register with debounced push-to-reset,
// fine/coarse steps, wrap or saturate at range ends and host load.
module rotary_encoder_v3
  import rotary_pkg::*;
#(
  parameter int unsigned WIDTH           = 15,
  parameter int unsigned MIN_VAL         = TUNE_MIN,
  parameter int unsigned MAX_VAL         = TUNE_MAX,
  parameter int unsigned INIT_VAL        = TUNE_CENTER,
  parameter int unsigned FINE_SHIFT      = 0,
  parameter int unsigned COARSE_SHIFT    = 5,
  parameter bit          WRAP_EN         = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rotary_a,
  input  logic             rotary_b,
  input  logic             rotary_press,
  input  logic             coarse,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value_out,
  output logic             press_out,
  output logic             step_up,
  output logic             step_down
);

  localparam int unsigned EW    = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             evt, dir;
  logic             press_s1_q, press_s2_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             up_q, up_d, down_q, down_d;
  logic [EW-1:0]    val_x, step_x, lo_x, hi_x, sum_x, floor_x, up_x, dn_x;
  logic [WIDTH-1:0] load_clamped;

  rotary_quad_decoder u_quad (
    .clk     (clk),
    .rst     (rst),
    .a_i     (rotary_a),
    .b_i     (rotary_b),
    .event_o (evt),
    .dir_o   (dir)
  );

  // Push debounce: accept a new level only after it persists DEBOUNCE_CYCLES cycles
  always_comb begin
    press_d = press_q;
    cnt_d   = '0;
    if (press_s2_q != press_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        press_d = press_s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Two extra bits keep value+step and MIN+step exact before clamping
  always_comb begin
    val_x   = EW'(value_q);
    step_x  = EW'(1) << step_shift(coarse, FINE_SHIFT, COARSE_SHIFT);
    lo_x    = EW'(MIN_VAL);
    hi_x    = EW'(MAX_VAL);
    sum_x   = val_x + step_x;
    floor_x = lo_x + step_x;
    if (val_x == hi_x)      up_x = WRAP_EN ? lo_x : hi_x;
    else if (sum_x > hi_x)  up_x = hi_x;
    else                    up_x = sum_x;
    if (val_x == lo_x)        dn_x = WRAP_EN ? hi_x : lo_x;
    else if (val_x < floor_x) dn_x = lo_x;
    else                      dn_x = val_x - step_x;
    load_clamped = WIDTH'(clamp_u32(32'(load_value), 32'(MIN_VAL), 32'(MAX_VAL)));
  end

  always_comb begin
    value_d = value_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    if (load) begin
      value_d = load_clamped;
    end else if (press_q) begin
      value_d = WIDTH'(INIT_VAL);
    end else if (evt) begin
      if (dir == DIR_DOWN) begin
        value_d = WIDTH'(dn_x);
        down_d  = 1'b1;
      end else begin
        value_d = WIDTH'(up_x);
        up_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_s1_q <= 1'b0;
      press_s2_q <= 1'b0;
      press_q    <= 1'b0;
      cnt_q      <= '0;
      value_q    <= WIDTH'(INIT_VAL);
      up_q       <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      press_s1_q <= rotary_press;
      press_s2_q <= press_s1_q;
      press_q    <= press_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      up_q       <= up_d;
      down_q     <= down_d;
    end
  end

  assign value_out = value_q;
  assign press_out = press_q;
  assign step_up   = up_q;
  assign step_down = down_q;

endmodule

// File: tb/tb_rotary_encoder_v3.sv
// Directed bench: a wrapping and a saturating instance driven in parallel.
module tb_rotary_encoder_v3;

  localparam int unsigned W = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ra = 1'b0, rb = 1'b0, rp = 1'b0, coarse = 1'b0, load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] val_w, val_s;
  logic         press_w, press_s, up_w, up_s, dn_w, dn_s;

  int checks = 0;
  int errors = 0;
  int cnt_up_w = 0, cnt_dn_w = 0, cnt_up_s = 0, cnt_dn_s = 0;

  always #5 clk = ~clk;

  rotary_encoder_v3 #(.WRAP_EN(1'b1), .DEBOUNCE_CYCLES(8)) u_wrap (
    .clk(clk), .rst(rst), .rotary_a(ra), .rotary_b(rb), .rotary_press(rp),
    .coarse(coarse), .load(load), .load_value(load_value),
    .value_out(val_w), .press_out(press_w), .step_up(up_w), .step_down(dn_w)
  );

  rotary_encoder_v3 #(.WRAP_EN(1'b0), .DEBOUNCE_CYCLES(8)) u_sat (
    .clk(clk), .rst(rst), .rotary_a(ra), .rotary_b(rb), .rotary_press(rp),
    .coarse(coarse), .load(load), .load_value(load_value),
    .value_out(val_s), .press_out(press_s), .step_up(up_s), .step_down(dn_s)
  );

  // Pulse-cycle counters; a single-cycle strobe adds exactly one
  always @(negedge clk) begin
    if (up_w) cnt_up_w <= cnt_up_w + 1;
    if (dn_w) cnt_dn_w <= cnt_dn_w + 1;
    if (up_s) cnt_up_s <= cnt_up_s + 1;
    if (dn_s) cnt_dn_s <= cnt_dn_s + 1;
  end

  typedef enum int {OP_LOAD, OP_CW, OP_CCW} op_e;
  typedef struct {
    op_e  op;
    logic crs;
    logic bounce;
    int   lval;
    int   exp_w;
    int   exp_s;
    int   exp_up;
    int   exp_dn;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bounce_a();
    ra = 1'b1; tick(1); ra = 1'b0; tick(1);
    ra = 1'b1; tick(1); ra = 1'b0; tick(1);
  endtask

  // One full detent starting and ending at {b,a}=00
  task automatic detent(input logic ccw, input logic crs, input logic bnc);
    coarse = crs;
    if (!ccw) begin
      if (bnc) bounce_a();
      ra = 1'b1; tick(3);
      rb = 1'b1; tick(3);
      ra = 1'b0; tick(3);
      rb = 1'b0; tick(8);
    end else begin
      rb = 1'b1; tick(3);
      if (bnc) bounce_a();
      ra = 1'b1; tick(3);
      rb = 1'b0; tick(3);
      ra = 1'b0; tick(8);
    end
    coarse = 1'b0;
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = W'(v); tick(1);
    load = 1'b0; tick(2);
  endtask

  int u0w, d0w, u0s, d0s;

  task automatic snap();
    u0w = cnt_up_w; d0w = cnt_dn_w; u0s = cnt_up_s; d0s = cnt_dn_s;
  endtask

  initial begin
    vecs[0]  = '{OP_LOAD, 1'b0, 1'b0, 8192,  8192,  8192,  0, 0};
    vecs[1]  = '{OP_CCW,  1'b1, 1'b1, 0,     8160,  8160,  0, 1};
    vecs[2]  = '{OP_CW,   1'b0, 1'b1, 0,     8161,  8161,  1, 0};
    vecs[3]  = '{OP_LOAD, 1'b0, 1'b0, 16383, 16383, 16383, 0, 0};
    vecs[4]  = '{OP_CW,   1'b0, 1'b0, 0,     0,     16383, 1, 0};
    vecs[5]  = '{OP_CCW,  1'b0, 1'b0, 0,     16383, 16382, 0, 1};
    vecs[6]  = '{OP_LOAD, 1'b0, 1'b0, 16370, 16370, 16370, 0, 0};
    vecs[7]  = '{OP_CW,   1'b1, 1'b0, 0,     16383, 16383, 1, 0};
    vecs[8]  = '{OP_LOAD, 1'b0, 1'b0, 0,     0,     0,     0, 0};
    vecs[9]  = '{OP_CCW,  1'b0, 1'b0, 0,     16383, 0,     0, 1};
    vecs[10] = '{OP_LOAD, 1'b0, 1'b0, 20,    20,    20,    0, 0};
    vecs[11] = '{OP_CCW,  1'b1, 1'b0, 0,     0,     0,     0, 1};
    vecs[12] = '{OP_LOAD, 1'b0, 1'b0, 20000, 16383, 16383, 0, 0};
    vecs[13] = '{OP_CW,   1'b1, 1'b0, 0,     0,     16383, 1, 0};
    vecs[14] = '{OP_LOAD, 1'b0, 1'b0, 100,   100,   100,   0, 0};
    vecs[15] = '{OP_CW,   1'b1, 1'b0, 0,     132,   132,   1, 0};
    vecs[16] = '{OP_CCW,  1'b1, 1'b0, 0,     100,   100,   0, 1};
    vecs[17] = '{OP_CCW,  1'b0, 1'b1, 0,     99,    99,    0, 1};

    // Reset state
    tick(2);
    check("rst_val_w", 32'(val_w), 8192);
    check("rst_val_s", 32'(val_s), 8192);
    check("rst_press", 32'({press_w, press_s}), 0);
    check("rst_pulses", 32'({up_w, dn_w, up_s, dn_s}), 0);
    rst = 1'b0;
    tick(3);
    check("post_rst_val", 32'(val_w), 8192);

    // First clockwise detent: value changes exactly 5 clocks after raw B edge
    snap();
    ra = 1'b1; tick(3);
    rb = 1'b1;
    tick(4);
    check("lat_early_val", 32'(val_w), 8192);
    check("lat_early_pulse", 32'(up_w), 0);
    tick(1);
    check("lat_val", 32'(val_w), 8193);
    check("lat_up", 32'(up_w), 1);
    tick(1);
    check("lat_up_1cyc", 32'(up_w), 0);
    ra = 1'b0; tick(3); rb = 1'b0; tick(8);
    check("lat_up_count", 32'(cnt_up_w - u0w), 1);
    check("lat_dn_count", 32'(cnt_dn_w - d0w), 0);

    // Table-driven loads and detents
    for (int i = 0; i < NV; i++) begin
      snap();
      case (vecs[i].op)
        OP_LOAD: do_load(vecs[i].lval);
        OP_CW:   detent(1'b0, vecs[i].crs, vecs[i].bounce);
        default: detent(1'b1, vecs[i].crs, vecs[i].bounce);
      endcase
      check($sformatf("v%0d_val_w", i), 32'(val_w), 32'(vecs[i].exp_w));
      check($sformatf("v%0d_val_s", i), 32'(val_s), 32'(vecs[i].exp_s));
      check($sformatf("v%0d_up_w", i), 32'(cnt_up_w - u0w), 32'(vecs[i].exp_up));
      check($sformatf("v%0d_dn_w", i), 32'(cnt_dn_w - d0w), 32'(vecs[i].exp_dn));
      check($sformatf("v%0d_up_s", i), 32'(cnt_up_s - u0s), 32'(vecs[i].exp_up));
      check($sformatf("v%0d_dn_s", i), 32'(cnt_dn_s - d0s), 32'(vecs[i].exp_dn));
    end

    // Short press glitch is rejected
    rp = 1'b1; tick(5); rp = 1'b0; tick(12);
    check("glitch_press", 32'(press_w), 0);
    check("glitch_val", 32'(val_w), 99);

    // Held press: press_out 8 cycles after sync, value pinned to INIT
    rp = 1'b1;
    tick(9);
    check("hold_press_early", 32'(press_w), 0);
    tick(1);
    check("hold_press", 32'(press_w), 1);
    check("hold_val_before", 32'(val_w), 99);
    tick(1);
    check("hold_val_init", 32'(val_w), 8192);
    snap();
    detent(1'b0, 1'b0, 1'b0);
    detent(1'b0, 1'b1, 1'b0);
    check("hold_val_w", 32'(val_w), 8192);
    check("hold_val_s", 32'(val_s), 8192);
    check("hold_no_pulse", 32'((cnt_up_w - u0w) + (cnt_up_s - u0s)), 0);
    rp = 1'b0; tick(12);
    check("release_press", 32'(press_w), 0);
    check("release_val", 32'(val_w), 8192);

    // Load wins over an event on the same edge
    do_load(100);
    snap();
    ra = 1'b1; tick(3);
    rb = 1'b1; tick(4);
    load = 1'b1; load_value = W'(20000); tick(1);
    load = 1'b0;
    check("load_evt_val_w", 32'(val_w), 16383);
    check("load_evt_val_s", 32'(val_s), 16383);
    ra = 1'b0; tick(3); rb = 1'b0; tick(8);
    check("load_evt_no_up", 32'(cnt_up_w - u0w), 0);
    check("load_evt_val_hold", 32'(val_w), 16383);

    // Reset wins over load on the same edge
    rst = 1'b1; load = 1'b1; load_value = W'(123); tick(1);
    rst = 1'b0; load = 1'b0;
    check("rst_load_val_w", 32'(val_w), 8192);
    check("rst_load_val_s", 32'(val_s), 8192);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
